// File: rtl/exp_f32_stream_packer.sv
// rtl/exp_f32_stream_packer.sv - packs a stream of fp32 samples into LANES-wide output beats
module exp_f32_stream_packer #(
    parameter int                      LANES        = 4,
    parameter int                      S_DATA_WIDTH = 32,
    parameter int                      M_DATA_WIDTH = LANES * S_DATA_WIDTH,
    parameter logic [S_DATA_WIDTH-1:0] PAD_VALUE    = 32'h0000_0000
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [S_DATA_WIDTH-1:0]   s_tdata,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [M_DATA_WIDTH-1:0]   m_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [31:0]               packet_count
);

    localparam int CNT_W      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LANE_BYTES = S_DATA_WIDTH / 8;
    localparam int KEEP_W     = M_DATA_WIDTH / 8;
    localparam logic [M_DATA_WIDTH-1:0] PAD_BEAT = {LANES{PAD_VALUE}};

    logic [CNT_W-1:0]        r_cnt;
    logic [M_DATA_WIDTH-1:0] r_buf;
    logic [M_DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_W-1:0]       r_m_tkeep;
    logic                    r_m_tlast;
    logic                    r_m_tvalid;
    logic [31:0]             r_packet_count;

    logic                    w_out_free;
    logic                    w_accept;
    logic                    w_complete;
    logic [M_DATA_WIDTH-1:0] w_buf_ins;
    logic [KEEP_W-1:0]       w_keep_next;

    // A held beat blocks input, so the stalled beat can never be overwritten
    assign w_out_free = !r_m_tvalid || m_tready;
    assign s_tready   = w_out_free && !reset;
    assign w_accept   = s_tvalid && s_tready;
    assign w_complete = w_accept && (s_tlast || (r_cnt == CNT_W'(LANES - 1)));

    // Buffer with the incoming sample dropped into its lane, plus the keep mask up to that lane
    always_comb begin
        w_buf_ins   = r_buf;
        w_keep_next = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_buf_ins[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_tdata;
            end
            if (CNT_W'(i) <= r_cnt) begin
                w_keep_next[i*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
    end

    // Assembly side: lane counter and partially filled buffer
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_cnt <= '0;
            r_buf <= PAD_BEAT;
        end else if (w_accept) begin
            if (w_complete) begin
                r_cnt <= '0;
                r_buf <= PAD_BEAT;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_buf <= w_buf_ins;
            end
        end
    end

    // Output side: a completing beat loads directly, replacing any beat accepted this cycle
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
        end else if (w_complete) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_buf_ins;
            r_m_tkeep  <= w_keep_next;
            r_m_tlast  <= s_tlast;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // Count packets as their final beat is handed off downstream
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_packet_count <= '0;
        end else if (r_m_tvalid && m_tready && r_m_tlast) begin
            r_packet_count <= r_packet_count + 32'd1;
        end
    end

    assign m_tdata      = r_m_tdata;
    assign m_tkeep      = r_m_tkeep;
    assign m_tlast      = r_m_tlast;
    assign m_tvalid     = r_m_tvalid;
    assign packet_count = r_packet_count;

endmodule

// File: tb/tb_exp_f32_stream_packer.sv
// tb/tb_exp_f32_stream_packer.sv - directed table, stall, reset and randomized scoreboard checks
module tb_exp_f32_stream_packer;

    logic         aclk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_tdata = '0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [31:0]  packet_count;

    int n_tests = 0;
    int n_fail  = 0;

    exp_f32_stream_packer dut (
        .aclk(aclk), .reset(reset),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .packet_count(packet_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         l;
        logic         rdy;
        logic         exp_srdy;
        logic         exp_mv;
        logic [127:0] exp_data;
        logic [15:0]  exp_keep;
        logic         exp_last;
        logic [31:0]  exp_pc;
    } row_t;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    row_t  rows[$];
    beat_t expq[$];
    logic [31:0] samp[$];
    logic        lastq[$];
    logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_row(input logic v, input logic [31:0] d, input logic l, input logic mv,
                           input logic [127:0] data, input logic [15:0] keep, input logic last,
                           input logic [31:0] pc);
        row_t r;
        r = '{v, d, l, 1'b1, 1'b1, mv, data, keep, last, pc};
        rows.push_back(r);
    endtask

    task automatic send(input logic v, input logic [31:0] d, input logic l);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int idx;
        int ph;
        int cycles;
        int len;
        logic in_hs;
        logic out_hs;
        logic [31:0] cur[$];
        beat_t b;

        // cycle-level table: 8-sample, 6-sample and 1-sample packets with m_tready high
        add_row(1, 32'h3F80_0000, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0001, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0002, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0003, 0, 1, {32'h3F80_0003, 32'h3F80_0002, 32'h3F80_0001, 32'h3F80_0000}, 16'hFFFF, 0, 0);
        add_row(1, 32'h3F80_0004, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0005, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0006, 0, 0, '0, '0, 0, 0);
        add_row(1, 32'h3F80_0007, 1, 1, {32'h3F80_0007, 32'h3F80_0006, 32'h3F80_0005, 32'h3F80_0004}, 16'hFFFF, 1, 0);
        add_row(0, 32'h0, 0, 0, '0, '0, 0, 1);
        add_row(1, 32'h4000_0000, 0, 0, '0, '0, 0, 1);
        add_row(1, 32'h4000_0001, 0, 0, '0, '0, 0, 1);
        add_row(1, 32'h4000_0002, 0, 0, '0, '0, 0, 1);
        add_row(1, 32'h4000_0003, 0, 1, {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000}, 16'hFFFF, 0, 1);
        add_row(1, 32'h4000_0004, 0, 0, '0, '0, 0, 1);
        add_row(1, 32'h4000_0005, 1, 1, {32'h0, 32'h0, 32'h4000_0005, 32'h4000_0004}, 16'h00FF, 1, 1);
        add_row(0, 32'h0, 0, 0, '0, '0, 0, 2);
        add_row(1, 32'h4049_0FDB, 1, 1, {32'h0, 32'h0, 32'h0, 32'h4049_0FDB}, 16'h000F, 1, 2);
        add_row(0, 32'h0, 0, 0, '0, '0, 0, 3);

        // reset state
        reset = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_s_tready", s_tready, 0);
        @(posedge aclk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_packet_count", packet_count, 0);
        reset = 1'b0;

        foreach (rows[i]) begin
            s_tvalid = rows[i].v;
            s_tdata  = rows[i].d;
            s_tlast  = rows[i].l;
            m_tready = rows[i].rdy;
            #1;
            chk($sformatf("row%0d_s_tready", i), s_tready, rows[i].exp_srdy);
            @(posedge aclk);
            #1;
            chk($sformatf("row%0d_m_tvalid", i), m_tvalid, rows[i].exp_mv);
            chk($sformatf("row%0d_packet_count", i), packet_count, rows[i].exp_pc);
            if (rows[i].exp_mv) begin
                chk($sformatf("row%0d_m_tdata", i), m_tdata, rows[i].exp_data);
                chk($sformatf("row%0d_m_tkeep", i), m_tkeep, rows[i].exp_keep);
                chk($sformatf("row%0d_m_tlast", i), m_tlast, rows[i].exp_last);
            end
        end

        // downstream stall for 5 cycles after a full beat completes
        m_tready = 1'b1;
        send(1, 32'h11, 0);
        send(1, 32'h12, 0);
        send(1, 32'h13, 0);
        send(1, 32'h14, 0);
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h15;
        s_tlast  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_s_tready", k), s_tready, 0);
            @(posedge aclk);
            #1;
            chk($sformatf("stall%0d_m_tvalid", k), m_tvalid, 1);
            chk($sformatf("stall%0d_m_tdata", k), m_tdata, {32'h14, 32'h13, 32'h12, 32'h11});
            chk($sformatf("stall%0d_m_tkeep", k), m_tkeep, 16'hFFFF);
            chk($sformatf("stall%0d_m_tlast", k), m_tlast, 0);
        end
        m_tready = 1'b1;
        #1;
        chk("release_s_tready", s_tready, 1);
        @(posedge aclk);
        #1;
        chk("release_m_tvalid", m_tvalid, 1);
        chk("release_m_tdata", m_tdata, {32'h0, 32'h0, 32'h0, 32'h15});
        chk("release_m_tkeep", m_tkeep, 16'h000F);
        chk("release_m_tlast", m_tlast, 1);
        send(0, 32'h0, 0);
        chk("release_drain_m_tvalid", m_tvalid, 0);
        chk("release_packet_count", packet_count, 4);

        // randomized packets with gapped input and random backpressure
        reset = 1'b1;
        send(0, 32'h0, 0);
        reset = 1'b0;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 17);
            cur.delete();
            for (int s = 0; s < len; s++) begin
                cur.push_back($urandom());
                samp.push_back(cur[s]);
                lastq.push_back(s == len - 1);
            end
            for (int c = 0; c < len; c += 4) begin
                b.d = '0;
                b.k = '0;
                for (int j = 0; j < 4; j++) begin
                    if (c + j < len) begin
                        b.d[j*32 +: 32] = cur[c+j];
                        b.k[j*4 +: 4]   = 4'hF;
                    end
                end
                b.l = (c + 4 >= len);
                expq.push_back(b);
            end
        end
        idx = 0;
        ph = 0;
        cycles = 0;
        while ((idx < samp.size() || expq.size() > 0) && cycles < 40000) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tvalid = (idx < samp.size()) && pat[ph];
            s_tdata  = (idx < samp.size()) ? samp[idx] : 32'h0;
            s_tlast  = (idx < samp.size()) ? lastq[idx] : 1'b0;
            #1;
            in_hs  = s_tvalid && s_tready;
            out_hs = m_tvalid && m_tready;
            if (out_hs) begin
                chk("rand_beat_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    chk("rand_beat", {m_tdata, m_tkeep, m_tlast}, {expq[0].d, expq[0].k, expq[0].l});
                    void'(expq.pop_front());
                end
            end
            @(posedge aclk);
            #1;
            if (in_hs) idx++;
            ph = (ph + 1) % 7;
            cycles++;
        end
        chk("rand_all_done", (idx == samp.size()) && (expq.size() == 0), 1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk("rand_packet_count", packet_count, 100);

        // reset in the middle of a packet, then a fresh packet
        send(0, 32'h0, 0);
        send(1, 32'hA1, 0);
        send(1, 32'hA2, 0);
        reset    = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hA3;
        s_tlast  = 1'b0;
        #1;
        chk("midrst_s_tready", s_tready, 0);
        @(posedge aclk);
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_m_tkeep", m_tkeep, 0);
        chk("midrst_m_tlast", m_tlast, 0);
        chk("midrst_packet_count", packet_count, 0);
        reset = 1'b0;
        send(1, 32'hB1, 0);
        send(1, 32'hB2, 0);
        send(1, 32'hB3, 0);
        send(1, 32'hB4, 1);
        chk("postrst_m_tvalid", m_tvalid, 1);
        chk("postrst_m_tdata", m_tdata, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        chk("postrst_m_tkeep", m_tkeep, 16'hFFFF);
        chk("postrst_m_tlast", m_tlast, 1);
        send(0, 32'h0, 0);
        chk("postrst_packet_count", packet_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
